// File: rtl/lh_digest_hex_serializer_pkg.sv
// Shared constants and types for the light_hash digest hex serializer.
package lh_pkg;

  localparam int DIGEST_W = 64;
  localparam int NIBBLES  = DIGEST_W / 4;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {IDLE, SEND, TERM} ser_state_t;

endpackage

// File: rtl/lh_digest_hex_serializer_if.sv
// Digest input, byte-stream output and status signals of the hex serializer.
interface lh_digest_hex_serializer_if;
  import lh_pkg::*;

  logic [DIGEST_W-1:0] digest_char;
  logic                digest_ready;
  logic [7:0]          out_char;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                overflow;
  logic                ovf_clear;

  // master: the serializer itself; slave: the hash core plus downstream consumer
  modport master (
    input  digest_char, digest_ready, out_ready, ovf_clear,
    output out_char, out_valid, busy, overflow
  );

  modport slave (
    output digest_char, digest_ready, out_ready, ovf_clear,
    input  out_char, out_valid, busy, overflow
  );

endinterface

// File: rtl/lh_digest_hex_serializer_ascii.sv
// Maps one 4-bit nibble to its ASCII hex character.
module lh_nibble_to_ascii
  import lh_pkg::*;
#(
  parameter bit UPPERCASE = 1'b0
) (
  input  logic [3:0] nibble_i,
  output logic [7:0] char_o
);

  always_comb begin
    char_o = ASCII_0 + {4'h0, nibble_i};
    if (nibble_i >= 4'd10) begin
      char_o = (UPPERCASE ? ASCII_UA : ASCII_LA) + {4'h0, nibble_i} - 8'd10;
    end
  end

endmodule

// File: rtl/lh_digest_hex_serializer.sv
// Streams each captured 64-bit digest as ASCII hex (MS nibble first), with an
// optional line feed and a one-deep pending buffer for back-to-back digests.
module lh_digest_hex_serializer
  import lh_pkg::*;
#(
  parameter bit UPPERCASE = 1'b0,
  parameter bit APPEND_LF = 1'b1
) (
  input logic                          clk,
  input logic                          rst,
  lh_digest_hex_serializer_if.master   bus
);

  localparam int CNT_W = $clog2(NIBBLES);

  ser_state_t          state_q, state_d;
  logic [DIGEST_W-1:0] shreg_q, shreg_d;
  logic [DIGEST_W-1:0] pend_q, pend_d;
  logic                pendValid_q, pendValid_d;
  logic [CNT_W-1:0]    nibCnt_q, nibCnt_d;
  logic                dr_q;
  logic                overflow_q, overflow_d;
  logic [7:0]          outChar_q, outChar_d;
  logic                outValid_q, outValid_d;
  logic                busy_q, busy_d;
  logic                captureEv, xfer, endOfDigest, ovfSet;
  logic [7:0]          nextNibChar;

  assign captureEv = bus.digest_ready && !dr_q;
  assign xfer      = outValid_q && bus.out_ready;

  // Character for the nibble that will be presented next cycle
  lh_nibble_to_ascii #(.UPPERCASE(UPPERCASE)) u_ascii (
    .nibble_i (shreg_d[DIGEST_W-1 -: 4]),
    .char_o   (nextNibChar)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    nibCnt_d    = nibCnt_q;
    pend_d      = pend_q;
    pendValid_d = pendValid_q;
    endOfDigest = 1'b0;
    ovfSet      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (captureEv) begin
          shreg_d  = bus.digest_char;
          nibCnt_d = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          shreg_d  = shreg_q << 4;
          nibCnt_d = nibCnt_q + 1'b1;
          if (nibCnt_q == CNT_W'(NIBBLES - 1)) begin
            if (APPEND_LF) state_d = TERM;
            else           endOfDigest = 1'b1;
          end
        end
      end
      TERM: begin
        if (xfer) endOfDigest = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Pending wins over a same-cycle capture so digest order is preserved
    if (endOfDigest) begin
      if (pendValid_q) begin
        shreg_d     = pend_q;
        pendValid_d = 1'b0;
        nibCnt_d    = '0;
        state_d     = SEND;
      end else if (captureEv) begin
        shreg_d  = bus.digest_char;
        nibCnt_d = '0;
        state_d  = SEND;
      end else begin
        state_d = IDLE;
      end
    end

    if (captureEv && state_q != IDLE && !(endOfDigest && !pendValid_q)) begin
      if (!pendValid_q || endOfDigest) begin
        pend_d      = bus.digest_char;
        pendValid_d = 1'b1;
      end else begin
        ovfSet = 1'b1;
      end
    end

    overflow_d = bus.ovf_clear ? 1'b0 : (overflow_q || ovfSet);
    outValid_d = (state_d != IDLE);
    busy_d     = (state_d != IDLE) || pendValid_d;
    unique case (state_d)
      SEND:    outChar_d = nextNibChar;
      TERM:    outChar_d = ASCII_LF;
      default: outChar_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      pend_q      <= '0;
      pendValid_q <= 1'b0;
      nibCnt_q    <= '0;
      dr_q        <= 1'b0;
      overflow_q  <= 1'b0;
      outChar_q   <= 8'h00;
      outValid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      pend_q      <= pend_d;
      pendValid_q <= pendValid_d;
      nibCnt_q    <= nibCnt_d;
      dr_q        <= bus.digest_ready;
      overflow_q  <= overflow_d;
      outChar_q   <= outChar_d;
      outValid_q  <= outValid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.out_char  = outChar_q;
  assign bus.out_valid = outValid_q;
  assign bus.busy      = busy_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: doc/lh_digest_hex_serializer.md
# lh_digest_hex_serializer

Downstream stage of `light_hash`. It captures each 64-bit digest when `digest_ready` rises and emits it as 16 ASCII hex characters over a valid/ready byte stream, most-significant nibble first, optionally followed by a line feed. A one-deep pending buffer absorbs a digest that arrives while the previous one is still being sent, so back-to-back digests stream with no gap.

## Interface
Parameters:
- `UPPERCASE`, default 0: 0 emits `a`–`f` (8'h61–8'h66); 1 emits `A`–`F` (8'h41–8'h46).
- `APPEND_LF`, default 1: 1 emits 8'h0A after the 16th character; 0 emits no terminator.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `digest_char`  in  64  digest from `light_hash`; sampled only on a capture event.
- `digest_ready`  in  1  level from `light_hash`; its 0→1 transition is a capture event.
- `out_char`  out  8  ASCII character.
- `out_valid`  out  1  `out_char` is valid.
- `out_ready`  in  1  downstream accepts; a transfer occurs when `out_valid && out_ready`.
- `busy`  out  1  high while in SEND or TERM, or while the pending buffer is full.
- `overflow`  out  1  sticky; set when a digest is dropped.
- `ovf_clear`  in  1  synchronous clear of `overflow`.

## Operation
- Edge detect: `dr_q` registers `digest_ready`. A capture event is `digest_ready && !dr_q`. `dr_q` resets to 0, so a level already high at reset release counts as an event.
- FSM states:
  - IDLE: on an event, load `digest_char` into `shreg`, set `nib_cnt = 0`, go to SEND.
  - SEND: `out_char = ascii(shreg[63:60])`. On each transfer, shift `shreg` left by 4 and increment `nib_cnt`. On the transfer with `nib_cnt == 15`, go to TERM if `APPEND_LF`, otherwise take the end-of-digest action.
  - TERM: `out_char = 8'h0A`. On transfer, take the end-of-digest action.
- End-of-digest action:
  - If the pending buffer is valid, move it into `shreg`, clear it, set `nib_cnt = 0`, stay or return to SEND.
  - Else, if a capture event occurs in the same cycle, load `digest_char` directly and go to SEND.
  - Else go to IDLE.
- Capture event while in SEND or TERM:
  - Pending empty: store `digest_char` in pending.
  - Pending full and the end-of-digest action is happening in the same cycle: pending moves to `shreg` and the new digest goes into pending. No drop.
  - Pending full otherwise: drop the new digest and set `overflow`.
- ASCII mapping: nibble n < 10 maps to 8'h30+n. Otherwise it maps to 8'h61+(n−10), or 8'h41+(n−10) when `UPPERCASE = 1`. Arithmetic is 8-bit with no wrap, since the maximum is 8'h66.
- `overflow`: `ovf_clear` has priority over a simultaneous set, so the set is lost in that cycle.

## Timing
- Reset values: `out_valid = 0`, `out_char = 8'h00`, `busy = 0`, `overflow = 0`, state IDLE, pending empty, `nib_cnt = 0`, `dr_q = 0`.
- Latency: a capture event in cycle N gives `out_valid = 1` with the first character in cycle N+1. All outputs are registered.
- Throughput: one character per cycle while `out_ready = 1`. There is no bubble between the last character of one digest and the first character of the next.
- Handshake rules:
  - While `out_valid && !out_ready`, `out_char` and `out_valid` hold.
  - `out_valid` never drops without a transfer, except on reset.
- Reset mid-stream: asynchronous clear. The in-flight digest and the pending digest are discarded and nothing resumes.
- A digest of length 16 (or 17 with `APPEND_LF`) completes in exactly that many transfers.

## Structure
- Shared package `lh_pkg` holds:
  - `DIGEST_W = 64` and `NIBBLES = DIGEST_W/4`.
  - `ASCII_0 = 8'h30`, `ASCII_UA = 8'h41`, `ASCII_LA = 8'h61`, `ASCII_LF = 8'h0A`.
  - `typedef enum logic [1:0] {IDLE, SEND, TERM} ser_state_t`.
- One combinational sub-module, `lh_nibble_to_ascii`, with inputs `nibble[3:0]` and `UPPERCASE`, and output `char[7:0]`.

## Test plan
- Basic: `digest_char = 64'h0123456789ABCDEF` with a `digest_ready` rise, `out_ready = 1`. Expect "0123456789abcdef" followed by 8'h0A: 17 transfers on consecutive cycles, with the first one in cycle N+1.
- Backpressure: same digest with `out_ready` toggling pseudo-randomly. Expect the same 17 characters in order, and `out_char` stable in every stalled cycle.
- Back-to-back: a second digest `64'hFFFF0000FFFF0000` rises during character 5 of the first. Expect "ffff0000ffff0000" plus LF to start the cycle after the first LF, with `overflow = 0`.
- Overflow: three rises during one send. Expect the third digest dropped and `overflow = 1`. Then pulse `ovf_clear`: expect `overflow = 0` on the next cycle, while the second digest still streams correctly.
- Reset mid-stream: assert `rst` after the 5th transfer. Expect `out_valid = 0` immediately and no further characters after release, until a new rise, which restarts from nibble 0.
- Parameters `UPPERCASE = 1`, `APPEND_LF = 0`: `64'hFEDCBA9876543210` produces exactly "FEDCBA9876543210" in 16 transfers, then IDLE with `busy = 0`.
